// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear control plus BCD mm:ss.cc timekeeping,
// sequencing an external 100 Hz tick divider through div_ena/div_rst/div_count.
module stopwatch_ctrl #(
  parameter logic [18:0] TICK_COUNT = 19'd499_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_stop,
  input  logic        btn_lap,
  input  logic        btn_clear,
  input  logic        div_tc,
  output logic        div_ena,
  output logic        div_rst,
  output logic [18:0] div_count,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] time_q, time_d;
  logic [23:0] lap_q, lap_d;
  logic [23:0] time_inc;
  logic        lap_active_q, lap_active_d;
  logic        overflow_q, overflow_d;
  logic        div_ena_q, div_rst_q, running_q;
  logic [23:0] disp_q;
  logic        tick;
  logic        wrap;
  logic [4:0]  c0_r, c1_r, s0_r, s1_r, m0_r, m1_r;

  // Returns {carry_out, next_digit} for one BCD digit rolling over at max_d.
  function automatic logic [4:0] digit_inc(input logic [3:0] d,
                                           input logic [3:0] max_d,
                                           input logic       cin);
    if (!cin) begin
      return {1'b0, d};
    end else if (d == max_d) begin
      return {1'b1, 4'd0};
    end else begin
      return {1'b0, d + 4'd1};
    end
  endfunction

  always_comb begin
    c0_r     = digit_inc(time_q[3:0],   4'd9, 1'b1);
    c1_r     = digit_inc(time_q[7:4],   4'd9, c0_r[4]);
    s0_r     = digit_inc(time_q[11:8],  4'd9, c1_r[4]);
    s1_r     = digit_inc(time_q[15:12], 4'd5, s0_r[4]);
    m0_r     = digit_inc(time_q[19:16], 4'd9, s1_r[4]);
    m1_r     = digit_inc(time_q[23:20], 4'd9, m0_r[4]);
    time_inc = {m1_r[3:0], m0_r[3:0], s1_r[3:0], s0_r[3:0], c1_r[3:0], c0_r[3:0]};
    // Carry out of m1 means every digit rolled to zero: 99:59.99 -> 00:00.00.
    wrap     = m1_r[4];
  end

  // The tick counts on the edge that leaves RUN too, since the divider was enabled.
  assign tick = (state_q == RUN) && div_tc;

  always_comb begin
    state_d      = state_q;
    time_d       = tick ? time_inc : time_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    overflow_d   = overflow_q | (tick & wrap);

    if (btn_clear) begin
      state_d      = IDLE;
      time_d       = 24'h0;
      lap_d        = 24'h0;
      lap_active_d = 1'b0;
      overflow_d   = 1'b0;
    end else if (btn_start_stop) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end else if (btn_lap && (state_q != IDLE)) begin
      if (!lap_active_q) begin
        lap_d        = time_q;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      time_q       <= 24'h0;
      lap_q        <= 24'h0;
      lap_active_q <= 1'b0;
      overflow_q   <= 1'b0;
      div_ena_q    <= 1'b0;
      div_rst_q    <= 1'b1;
      running_q    <= 1'b0;
      disp_q       <= 24'h0;
    end else begin
      state_q      <= state_d;
      time_q       <= time_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      overflow_q   <= overflow_d;
      div_ena_q    <= (state_d == RUN);
      div_rst_q    <= (state_d == IDLE);
      running_q    <= (state_d == RUN);
      disp_q       <= lap_active_d ? lap_d : time_d;
    end
  end

  assign div_ena    = div_ena_q;
  assign div_rst    = div_rst_q;
  assign div_count  = TICK_COUNT;
  assign disp_bcd   = disp_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign overflow   = overflow_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: divider model, centisecond reference model and
// a per-cycle expected queue, plus directed checks on the key scenarios.
module tb_stopwatch_ctrl;

  localparam logic [18:0] TICK = 19'd3;
  localparam int W = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start_stop = 1'b0;
  logic        btn_lap = 1'b0;
  logic        btn_clear = 1'b0;
  logic        div_tc;
  logic        div_ena, div_rst, running, lap_active, overflow;
  logic [18:0] div_count;
  logic [23:0] disp_bcd;
  logic [1:0]  dbg_state;

  stopwatch_ctrl #(.TICK_COUNT(TICK)) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_start_stop (btn_start_stop),
    .btn_lap        (btn_lap),
    .btn_clear      (btn_clear),
    .div_tc         (div_tc),
    .div_ena        (div_ena),
    .div_rst        (div_rst),
    .div_count      (div_count),
    .disp_bcd       (disp_bcd),
    .running        (running),
    .lap_active     (lap_active),
    .overflow       (overflow),
    .dbg_state      (dbg_state)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- tick divider model ----
  logic [18:0] div_cnt = '0;
  always @(posedge clk) begin
    if (div_rst)      div_cnt <= '0;
    else if (div_ena) div_cnt <= div_tc ? '0 : div_cnt + 19'd1;
  end
  assign div_tc = div_ena && (div_cnt == div_count);

  // ---- reference model (time kept as a plain centisecond count) ----
  int  m_state;
  int  m_cs, m_lap_cs;
  bit  m_lapact, m_ovf;
  logic [W-1:0] exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int cs);
    int m, s, c;
    m = cs / 6000;
    s = (cs / 100) % 60;
    c = cs % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  function automatic logic [W-1:0] exp_vec();
    logic [23:0] d;
    d = m_lapact ? to_bcd(m_lap_cs) : to_bcd(m_cs);
    return {2'(m_state), (m_state == 1), m_lapact, m_ovf,
            (m_state == 1), (m_state == 0), TICK, d};
  endfunction

  task automatic m_reset();
    m_state  = 0;
    m_cs     = 0;
    m_lap_cs = 0;
    m_lapact = 0;
    m_ovf    = 0;
  endtask

  // ---- driver: one clock cycle of button stimulus, scored after the edge ----
  task automatic step(input bit ss, input bit lp, input bit cl);
    logic tc;
    int   old_cs;
    logic [W-1:0] got;
    @(negedge clk);
    btn_start_stop = ss;
    btn_lap        = lp;
    btn_clear      = cl;
    tc     = div_tc;
    old_cs = m_cs;
    if (cl) begin
      m_reset();
    end else begin
      if (m_state == 1 && tc) begin
        m_cs++;
        if (m_cs == 600000) begin
          m_cs  = 0;
          m_ovf = 1;
        end
      end
      if (ss) begin
        m_state = (m_state == 1) ? 2 : 1;
      end else if (lp && m_state != 0) begin
        if (!m_lapact) begin
          m_lap_cs = old_cs;
          m_lapact = 1;
        end else begin
          m_lapact = 0;
        end
      end
    end
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    got = {dbg_state, running, lap_active, overflow, div_ena, div_rst, div_count, disp_bcd};
    check("scoreboard", 64'(got), 64'(exp_q.pop_front()));
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  task automatic run_until_cs(input int target, input int budget);
    int n;
    n = 0;
    while (m_cs != target && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    check("run_budget", 64'(n < budget), 64'd1);
  endtask

  // ---- stimulus ----
  initial begin
    int   n;
    logic [23:0] prev;
    m_reset();

    // reset values
    #22;
    check("rst_disp",   64'(disp_bcd),   64'h0);
    check("rst_state",  64'(dbg_state),  64'd0);
    check("rst_ena",    64'(div_ena),    64'd0);
    check("rst_divrst", 64'(div_rst),    64'd1);
    check("rst_count",  64'(div_count),  64'd3);
    check("rst_run",    64'(running),    64'd0);
    check("rst_lap",    64'(lap_active), 64'd0);
    check("rst_ovf",    64'(overflow),   64'd0);
    @(negedge clk);
    rst = 1'b1;

    // start, first ticks
    step(1, 0, 0);
    check("start_ena", 64'(div_ena), 64'd1);
    repeat (4) step(0, 0, 0);
    check("tick1", 64'(disp_bcd), 64'h000001);
    repeat (4) step(0, 0, 0);
    check("tick2", 64'(disp_bcd), 64'h000002);

    // seconds to minutes carry
    run_until_cs(5999, 30000);
    check("at_5999", 64'(disp_bcd), 64'h005999);
    run_until_cs(6000, 10);
    check("min_carry", 64'(disp_bcd), 64'h010000);

    // pause mid-tick holds the divider; resume finishes the partial tick
    step(0, 0, 0);
    step(1, 0, 0);
    prev = disp_bcd;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0);
      check("pause_ena", 64'(div_ena), 64'd0);
    end
    check("pause_hold", 64'(disp_bcd), 64'(prev));
    step(1, 0, 0);
    n = 0;
    while (disp_bcd == prev && n < 10) begin
      step(0, 0, 0);
      n++;
    end
    check("resume_lat", 64'(n), 64'd2);

    // lap freeze and release
    step(0, 0, 1);
    step(1, 0, 0);
    run_until_cs(5, 100);
    step(0, 1, 0);
    run_until_cs(8, 100);
    check("lap_hold", 64'(disp_bcd), 64'h000005);
    check("lap_flag", 64'(lap_active), 64'd1);
    step(0, 1, 0);
    check("lap_release", 64'(disp_bcd), 64'h000008);

    // wrap past 99:59.99
    step(1, 0, 0);
    force dut.time_q = 24'h995999;
    m_cs = 599999;
    step(0, 0, 0);
    release dut.time_q;
    step(1, 0, 0);
    run_until_cs(0, 10);
    check("wrap_disp", 64'(disp_bcd), 64'h0);
    check("wrap_ovf",  64'(overflow), 64'd1);
    step(0, 0, 1);
    check("clr_ovf",   64'(overflow),  64'd0);
    check("clr_state", 64'(dbg_state), 64'd0);

    // same-cycle priorities
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    step(0, 1, 0);
    step(1, 1, 1);
    check("all3_state", 64'(dbg_state),  64'd0);
    check("all3_disp",  64'(disp_bcd),   64'h0);
    check("all3_lap",   64'(lap_active), 64'd0);
    step(0, 1, 0);
    check("idle_lap",   64'(lap_active), 64'd0);
    check("idle_state", 64'(dbg_state),  64'd0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    check("ss_lap_state", 64'(dbg_state),  64'd1);
    check("ss_lap_lap",   64'(lap_active), 64'd1);

    // random button traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 60) == 0);
    end

    // reset asserted mid-run
    step(0, 0, 1);
    step(1, 0, 0);
    repeat (6) step(0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_disp",  64'(disp_bcd),  64'h0);
    check("arst_state", 64'(dbg_state), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    check("post_rst_tick", 64'(disp_bcd), 64'h000001);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timekeeping block for the stopwatch. It sequences the 100 Hz tick divider by driving its enable, reload and terminal-count value, and consumes its terminal-count pulse. It accumulates elapsed time as BCD mm:ss.cc and implements start/stop, lap freeze and clear from pre-debounced, single-cycle button pulses. It sits between the button conditioning logic and the seven-segment display driver.

## Interface
- TICK_COUNT, 19'd499_999, divider reload value; tick period = TICK_COUNT+1 clk cycles (100 Hz at 50 MHz)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- btn_start_stop  in  1  one-cycle pulse, toggles run/pause
- btn_lap  in  1  one-cycle pulse, toggles lap freeze
- btn_clear  in  1  one-cycle pulse, returns to zero/idle
- div_tc  in  1  divider terminal count, combinational, valid only while div_ena=1
- div_ena  out  1  divider enable
- div_rst  out  1  divider reload (active-high, divider-side sync)
- div_count  out  19  divider reload value, constant TICK_COUNT
- disp_bcd  out  24  {m1,m0,s1,s0,c1,c0}, 4 bits BCD each
- running  out  1  1 in RUN
- lap_active  out  1  display frozen on lap capture
- overflow  out  1  sticky, set on wrap past 99:59.99

## Operation
- FSM states: IDLE, RUN, PAUSE; reset state IDLE.
- Moore decodes: div_ena = (state==RUN); div_rst = (state==IDLE); running = (state==RUN).
- Same-cycle button priority: clear > start_stop > lap; lower-priority pulses that cycle are dropped.
- btn_clear, any state: next IDLE; time, lap register, lap_active and overflow all go to 0.
- btn_start_stop: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
- PAUSE holds the divider count, because div_ena=0 and div_rst=0. Resume continues the partial tick; no reload.
- btn_lap in RUN or PAUSE:
  - if lap_active=0: lap_reg <= current time (pre-increment value this cycle), lap_active <= 1.
  - else lap_active <= 0.
- btn_lap in IDLE: ignored.
- Time increment on any edge with state==RUN and div_tc==1. This includes the edge where start_stop moves RUN->PAUSE, because ena was high that cycle.
- Increment rules:
  - c0 9->0 carries to c1; c1 9->0 carries to s0; s0 9->0 carries to s1.
  - s1 5->0 carries to m0; m0 9->0 carries to m1.
  - m1 9->0 wraps the whole time to 00:00.00 and sets overflow.
- Time keeps accumulating while lap_active=1; only the display is frozen.
- disp_bcd = lap_active ? lap_reg : time.
- div_count is tied to TICK_COUNT in all states.

## Timing
- Reset (rst=0, asynchronous) values:
  - state IDLE
  - time, lap_reg and disp_bcd all 24'h0
  - lap_active=0, overflow=0, running=0
  - div_ena=0, div_rst=1, div_count=TICK_COUNT
- Button pulse sampled at edge k; state, lap and clear effects are visible after edge k (1-cycle latency).
- From RUN entry, the first div_tc arrives in RUN cycle TICK_COUNT+1. disp_bcd shows 00:00.01 after that edge.
- Tick increment to disp_bcd update: 1 edge. No added pipeline.
- Clear mid-tick reloads the divider via div_rst in IDLE. The next start counts a full period.
- Reset deasserted mid-run: the block comes up in IDLE; no tick is lost or double-counted.

## Test plan
- TICK_COUNT=3: reset, start pulse -> div_ena=1 next cycle; disp_bcd=24'h000001 after 4 RUN cycles, 24'h000002 after 8.
- Run to 00:59.99, one more tick -> disp_bcd=24'h010000.
- Force time to 99:59.99, one tick -> disp_bcd=0 and overflow=1. Then clear -> overflow=0, state IDLE.
- Pause after 2 RUN cycles into a tick, hold 10 cycles, resume -> next increment after exactly 2 more RUN cycles; div_ena=0 throughout the pause.
- Lap at 00:00.05, run 3 ticks -> disp_bcd=24'h000005 held with lap_active=1; lap again -> 24'h000008.
- Simultaneous clear+start_stop+lap in RUN -> IDLE, all zero, lap_active=0. Lap pulse in IDLE -> no change. Start_stop+lap together in PAUSE -> RUN, lap_active unchanged.
